// File: rtl/mem_access.sv
// Memory-stage access controller: turns execute-stage load/store results into
// a req/ready/rvalid handshake with a variable-latency data memory, stalls the
// upstream pipeline while an access is in flight, and reports failures.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; accept an aligned op from execute
// REQ   | mem_req asserted, waiting for the memory to accept
// WAIT  | read accepted, waiting for mem_rvalid
// DONE  | access finished; one-cycle done pulse, upstream advances
module mem_access #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic [15:0] in_aluOut,
    input  logic [15:0] in_outData,
    output logic        stall,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             mem_op;
    logic             tmo;
    logic             accept;
    logic             load_rd;
    logic             load_fail;
    logic             set_err;

    assign mem_op  = in_valid & (in_memRead | in_memWrite);
    // Greater-or-equal so a read that was accepted on the last allowed cycle
    // still times out in WAIT instead of the counter running past the limit.
    assign tmo     = (cnt >= TMO_LAST);
    assign mem_req = (state == REQ);
    assign done    = (state == DONE);

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        accept    = 1'b0;
        load_rd   = 1'b0;
        load_fail = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (!in_aluOut[0]) begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ready) begin
                    if (mem_err) begin
                        set_err   = 1'b1;
                        load_fail = ~mem_wr;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = mem_wr ? DONE : WAIT;
                    end
                end else if (tmo) begin
                    set_err   = 1'b1;
                    load_fail = ~mem_wr;
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    load_rd   = ~mem_err;
                    load_fail = mem_err;
                    set_err   = mem_err;
                    state_nxt = DONE;
                end else if (tmo) begin
                    set_err   = 1'b1;
                    load_fail = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latches, timeout counter, load data and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_wr    <= 1'b0;
            cnt       <= '0;
            rd_data   <= 16'h0000;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr  <= in_aluOut;
                mem_wdata <= in_outData;
                mem_wr    <= in_memWrite;
                cnt       <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (load_rd) begin
                rd_data <= mem_rdata;
            end else if (load_fail) begin
                rd_data <= 16'hFFFF;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access. Two instances share all inputs: one with the
// default timeout, one with TIMEOUT=4 for the timeout scenarios.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_memRead;
    logic        in_memWrite;
    logic [15:0] in_aluOut;
    logic [15:0] in_outData;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_err;

    logic        stall, done, err, mem_req, mem_wr;
    logic [15:0] rd_data, mem_addr, mem_wdata;
    logic        t_stall, t_done, t_err, t_mem_req, t_mem_wr;
    logic [15:0] t_rd_data, t_mem_addr, t_mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_memRead (in_memRead),
        .in_memWrite(in_memWrite),
        .in_aluOut  (in_aluOut),
        .in_outData (in_outData),
        .stall      (stall),
        .done       (done),
        .rd_data    (rd_data),
        .err        (err),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    mem_access #(.TIMEOUT(4), .CNT_W(8)) u_dut_tmo (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_memRead (in_memRead),
        .in_memWrite(in_memWrite),
        .in_aluOut  (in_aluOut),
        .in_outData (in_outData),
        .stall      (t_stall),
        .done       (t_done),
        .rd_data    (t_rd_data),
        .err        (t_err),
        .mem_req    (t_mem_req),
        .mem_wr     (t_mem_wr),
        .mem_addr   (t_mem_addr),
        .mem_wdata  (t_mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data);
        in_valid    = v;
        in_memRead  = rd;
        in_memWrite = wr;
        in_aluOut   = addr;
        in_outData  = data;
    endtask

    task automatic set_mem(input logic rdy, input logic rv, input logic [15:0] rdat, input logic e);
        mem_ready  = rdy;
        mem_rvalid = rv;
        mem_rdata  = rdat;
        mem_err    = e;
    endtask

    task automatic do_reset();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();

        // Reset values, with an aligned op presented while rst is held.
        set_op(1'b1, 1'b0, 1'b1, 16'h0010, 16'h1111);
        #1;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wr", mem_wr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        tick();
        check_eq("rst_hold_req", mem_req, 0);
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;
        tick();

        // Store 0xBEEF to 0x0010, ready on first REQ cycle.
        set_op(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        #1;
        check_eq("st_c0_stall", stall, 1);
        check_eq("st_c0_req", mem_req, 0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("st_c1_req", mem_req, 1);
        check_eq("st_c1_wr", mem_wr, 1);
        check_eq("st_c1_addr", mem_addr, 16'h0010);
        check_eq("st_c1_wdata", mem_wdata, 16'hBEEF);
        check_eq("st_c1_stall", stall, 1);
        check_eq("st_c1_done", done, 0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("st_c2_done", done, 1);
        check_eq("st_c2_stall", stall, 0);
        check_eq("st_c2_req", mem_req, 0);
        check_eq("st_c2_addr", mem_addr, 16'h0010);
        check_eq("st_c2_rd_data", rd_data, 0);
        check_eq("st_c2_err", err, 0);
        tick();
        #1;
        check_eq("st_c3_done", done, 0);

        // Load from 0x0020: ready on the 4th REQ cycle (with a stray rvalid
        // that must be ignored), rvalid 0x1234 two cycles later.
        set_op(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        #1;
        check_eq("ld_c0_stall", stall, 1);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_eq("ld_req_wait", mem_req, 1);
            check_eq("ld_req_stall", stall, 1);
            tick();
        end
        check_eq("ld_req_wr", mem_wr, 0);
        check_eq("ld_req_addr", mem_addr, 16'h0020);
        set_mem(1'b1, 1'b1, 16'hDEAD, 1'b0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("ld_wait_req", mem_req, 0);
        check_eq("ld_wait_stall", stall, 1);
        check_eq("ld_wait_done", done, 0);
        tick();
        set_mem(1'b0, 1'b1, 16'h1234, 1'b0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("ld_done", done, 1);
        check_eq("ld_done_stall", stall, 0);
        check_eq("ld_rd_data", rd_data, 16'h1234);
        check_eq("ld_err", err, 0);
        tick();
        // Store must leave rd_data untouched.
        set_op(1'b1, 1'b0, 1'b1, 16'h0002, 16'h7777);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("st2_done", done, 1);
        check_eq("st2_rd_data", rd_data, 16'h1234);
        tick();

        // Misaligned load.
        set_op(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0);
        #1;
        check_eq("mis_stall", stall, 0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check_eq("mis_err", err, 1);
        check_eq("mis_req", mem_req, 0);
        check_eq("mis_done", done, 0);
        check_eq("mis_stall2", stall, 0);
        tick();
        tick();
        check_eq("mis_err_sticky", err, 1);
        check_eq("mis_req_late", mem_req, 0);

        // Timeout on the TIMEOUT=4 instance: load with no mem_ready.
        do_reset();
        check_eq("tmo_err_cleared", t_err, 0);
        set_op(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            check_eq("tmo_req", t_mem_req, 1);
            check_eq("tmo_no_done", t_done, 0);
            tick();
        end
        check_eq("tmo_done", t_done, 1);
        check_eq("tmo_err", t_err, 1);
        check_eq("tmo_rd_data", t_rd_data, 16'hFFFF);
        check_eq("tmo_stall", t_stall, 0);
        check_eq("tmo_long_still_req", mem_req, 1);
        check_eq("tmo_long_no_err", err, 0);

        // Handshakes on the limit cycle win over the timeout.
        do_reset();
        set_op(1'b1, 1'b1, 1'b0, 16'h0070, 16'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        tick();
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("edge_req4", t_mem_req, 1);
        tick();
        set_mem(1'b0, 1'b1, 16'h0BAD, 1'b0);
        #1;
        check_eq("edge_wait_done", t_done, 0);
        check_eq("edge_wait_stall", t_stall, 1);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("edge_done", t_done, 1);
        check_eq("edge_err", t_err, 0);
        check_eq("edge_rd_data", t_rd_data, 16'h0BAD);

        // mem_err alongside rvalid.
        do_reset();
        set_op(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        set_mem(1'b0, 1'b1, 16'h5A5A, 1'b1);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("merr_done", done, 1);
        check_eq("merr_err", err, 1);
        check_eq("merr_rd_data", rd_data, 16'hFFFF);

        // Reset mid-WAIT, then a stray rvalid; then a normal store.
        do_reset();
        set_op(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rw_rst_stall", stall, 0);
        tick();
        rst = 1'b0;
        set_mem(1'b0, 1'b1, 16'hAAAA, 1'b0);
        #1;
        check_eq("rw_idle_req", mem_req, 0);
        check_eq("rw_idle_stall", stall, 0);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("rw_no_done", done, 0);
        check_eq("rw_rd_data", rd_data, 0);
        check_eq("rw_err", err, 0);
        set_op(1'b1, 1'b0, 1'b1, 16'h0060, 16'h5555);
        tick();
        set_op(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_mem(1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("rw_st_req", mem_req, 1);
        check_eq("rw_st_addr", mem_addr, 16'h0060);
        check_eq("rw_st_wdata", mem_wdata, 16'h5555);
        tick();
        set_mem(1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check_eq("rw_st_done", done, 1);
        check_eq("rw_st_err", err, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
